// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS core: reset PC, bubble word,
// stage numbering and the word carried between pipeline stages.
package mips_pkg;

    // Fetch starts here after reset unless a core overrides it.
    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;

    // All-zero word: a bubble, and also the encoding of sll $0,$0,0.
    localparam logic [31:0] NOP = 32'h0000_0000;

    // jal writes the address after the delay slot into $ra.
    localparam logic [31:0] LINK_OFFSET = 32'd8;

    // Stage numbering shared with the hazard controller and datapath.
    localparam int unsigned STAGE_F    = 0;
    localparam int unsigned STAGE_D    = 1;
    localparam int unsigned STAGE_E    = 2;
    localparam int unsigned STAGE_M    = 3;
    localparam int unsigned STAGE_W    = 4;
    localparam int unsigned NUM_STAGES = 5;

    // What travels down the pipe with each instruction.
    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc8;
    } stage_word_t;

    // Link value for the instruction fetched at pc (wraps mod 2^32).
    function automatic logic [31:0] link_addr(input logic [31:0] pc);
        return pc + LINK_OFFSET;
    endfunction

    // True when the word in a stage does no architectural work.
    function automatic logic is_bubble(input logic [31:0] ir);
        return (ir == NOP);
    endfunction

endpackage

// File: rtl/pipe_stage_regs_if.sv
// Bundle of the stall/fetch inputs and per-stage outputs of the pipeline
// register chain. The master side is the fetch logic plus hazard controller;
// the slave side is pipe_stage_regs.
interface pipe_stage_regs_if #(
    parameter int CNT_W = 32
);
    logic             stall;
    logic [31:0]      npc;
    logic [31:0]      instr_f;

    logic [31:0]      pc_f;
    logic [31:0]      ir_d;
    logic [31:0]      ir_e;
    logic [31:0]      ir_m;
    logic [31:0]      ir_w;
    logic [31:0]      pc8_d;
    logic [31:0]      pc8_e;
    logic [31:0]      pc8_m;
    logic [31:0]      pc8_w;
    logic [CNT_W-1:0] retired_cnt;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output stall, npc, instr_f,
        input  pc_f,
        input  ir_d, ir_e, ir_m, ir_w,
        input  pc8_d, pc8_e, pc8_m, pc8_w,
        input  retired_cnt, stall_cnt
    );

    modport slave (
        input  stall, npc, instr_f,
        output pc_f,
        output ir_d, ir_e, ir_m, ir_w,
        output pc8_d, pc8_e, pc8_m, pc8_w,
        output retired_cnt, stall_cnt
    );

endinterface

// File: rtl/pipe_stage_regs_pipe_reg.sv
// Generic pipeline boundary register: hold when en=0, load zero when clr=1
// (clr beats en), synchronous active-high reset to RESET_VAL.
module pipe_reg #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // Reset first, then bubble insertion, then normal capture or hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= RESET_VAL;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pipe_stage_regs.sv
// Pipeline register chain of the 5-stage MIPS core: fetch PC, the D/E/M/W
// instruction and PC+8 registers, plus retired-instruction and stall-cycle
// performance counters. A stall freezes F and D and pushes a bubble into E;
// M and W always advance so older instructions drain past the hazard.
module pipe_stage_regs
    import mips_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
    parameter int          CNT_W    = 32
) (
    input  logic               clk,
    input  logic               reset,
    pipe_stage_regs_if.slave   bus
);

    localparam int          SW      = $bits(stage_word_t);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic        w_fdEn;
    logic        w_deClr;
    logic [31:0] w_pcF;
    logic [31:0] w_pc8F;

    stage_word_t w_fWord;
    stage_word_t w_dWord;
    stage_word_t w_eWord;
    stage_word_t w_mWord;
    stage_word_t w_wWord;

    logic [CNT_W-1:0] r_retiredCnt;
    logic [CNT_W-1:0] r_stallCnt;

    // F and D freeze on a stall; E takes a bubble instead of the held D word.
    assign w_fdEn  = ~bus.stall;
    assign w_deClr = bus.stall;

    // The link value is formed from the fetch PC as the instruction enters D.
    assign w_pc8F     = link_addr(w_pcF);
    assign w_fWord.ir  = bus.instr_f;
    assign w_fWord.pc8 = w_pc8F;

    // Fetch PC: only register that resets to something other than zero.
    pipe_reg #(
        .WIDTH     (32),
        .RESET_VAL (PC_RESET)
    ) u_pcF (
        .clk   (clk),
        .reset (reset),
        .i_en  (w_fdEn),
        .i_clr (1'b0),
        .i_d   (bus.npc),
        .o_q   (w_pcF)
    );

    // F/D boundary: holds the instruction the hazard controller is stalling.
    pipe_reg #(
        .WIDTH     (SW),
        .RESET_VAL ('0)
    ) u_fd (
        .clk   (clk),
        .reset (reset),
        .i_en  (w_fdEn),
        .i_clr (1'b0),
        .i_d   (w_fWord),
        .o_q   (w_dWord)
    );

    // D/E boundary: one bubble per stall cycle.
    pipe_reg #(
        .WIDTH     (SW),
        .RESET_VAL ('0)
    ) u_de (
        .clk   (clk),
        .reset (reset),
        .i_en  (1'b1),
        .i_clr (w_deClr),
        .i_d   (w_dWord),
        .o_q   (w_eWord)
    );

    // E/M boundary: always advances.
    pipe_reg #(
        .WIDTH     (SW),
        .RESET_VAL ('0)
    ) u_em (
        .clk   (clk),
        .reset (reset),
        .i_en  (1'b1),
        .i_clr (1'b0),
        .i_d   (w_eWord),
        .o_q   (w_mWord)
    );

    // M/W boundary: always advances.
    pipe_reg #(
        .WIDTH     (SW),
        .RESET_VAL ('0)
    ) u_mw (
        .clk   (clk),
        .reset (reset),
        .i_en  (1'b1),
        .i_clr (1'b0),
        .i_d   (w_mWord),
        .o_q   (w_wWord)
    );

    // Count an instruction on the edge at which it leaves W; bubbles and
    // the all-zero sll are indistinguishable and both skipped.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_retiredCnt <= '0;
        end else if (!is_bubble(w_wWord.ir)) begin
            r_retiredCnt <= r_retiredCnt + CNT_ONE;
        end
    end

    // Count cycles in which the hazard controller held the front end;
    // reset wins so a stall during reset is not counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stallCnt <= '0;
        end else if (bus.stall) begin
            r_stallCnt <= r_stallCnt + CNT_ONE;
        end
    end

    assign bus.pc_f        = w_pcF;
    assign bus.ir_d        = w_dWord.ir;
    assign bus.ir_e        = w_eWord.ir;
    assign bus.ir_m        = w_mWord.ir;
    assign bus.ir_w        = w_wWord.ir;
    assign bus.pc8_d       = w_dWord.pc8;
    assign bus.pc8_e       = w_eWord.pc8;
    assign bus.pc8_m       = w_mWord.pc8;
    assign bus.pc8_w       = w_wWord.pc8;
    assign bus.retired_cnt = r_retiredCnt;
    assign bus.stall_cnt   = r_stallCnt;

endmodule
